shift_rows_pipe: RTL and testbench
==================================

SHIFT_ROWS_PIPE -- requirements
Module: shift_rows_pipe

Interface
REQ-001 SHALL have parameter NB, default 4, meaning state columns; legal values 4, 6, 8 (AES/Rijndael 128/192/256-bit block).
REQ-002 SHALL have parameter TAG_W, default 4, meaning width of the sideband tag carried with each block.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_valid  input  1  meaning an input block is offered.
REQ-006 SHALL have port in_ready  output  1  meaning the block can be accepted this cycle.
REQ-007 SHALL have port in_inv  input  1  meaning mode: 1 = inverse ShiftRows, 0 = forward.
REQ-008 SHALL have port in_data  input  32*NB  meaning the input state.
REQ-009 SHALL have port in_tag  input  TAG_W  meaning a tag passed through unchanged.
REQ-010 SHALL have port out_valid  output  1  meaning an output block is presented.
REQ-011 SHALL have port out_ready  input  1  meaning the consumer accepts the output.
REQ-012 SHALL have port out_data  output  32*NB  meaning the shifted state.
REQ-013 SHALL have port out_tag  output  TAG_W  meaning the tag of the presented block.

Function
REQ-014 SHALL treat the state as row-major bytes: byte k occupies bits [32*NB-1-8k -: 8]; row r, column c is byte r*NB+c.
REQ-015 SHALL use row offsets 0,1,2,3 for NB=4 and NB=6, and 0,1,3,4 for NB=8.
REQ-016 SHALL compute forward mode as out[r][c] = in[r][(c+off_r) mod NB] and inverse mode as out[r][c] = in[r][(c-off_r) mod NB].
REQ-017 SHALL accept a block on any rising edge with in_valid and in_ready high, and sample in_inv and in_tag on that same edge.
REQ-018 SHALL store the transformed block in a 2-entry FIFO; out_data/out_tag show the oldest entry; out_valid = FIFO not empty.
REQ-019 SHALL have a latency of 1 cycle: a block accepted on edge N is presented from edge N onward (visible in cycle N+1).
REQ-020 SHALL drive in_ready = (occupancy < 2) from registered state only; no combinational path from out_ready to in_ready.
REQ-021 SHALL retire the head entry on any edge with out_valid and out_ready high.
REQ-022 SHALL with occupancy 1 and simultaneous accept and retire, keep occupancy at 1 with the new block presented next.
REQ-023 SHALL with occupancy 2, accept no input; a retire that cycle drops occupancy to 1 and raises in_ready the next cycle.
REQ-024 SHALL hold out_data and out_tag stable while out_valid is high and out_ready is low.
REQ-025 SHALL sustain one block per cycle when out_ready stays high.
REQ-026 SHALL preserve transaction order; the mode may change on every block.

Reset
REQ-027 SHALL on rst_n low immediately empty the FIFO, drive out_valid=0 and in_ready=0, and clear pointers and data/tag registers to 0.
REQ-028 SHALL drive in_ready=1 from the first clock edge after rst_n deasserts; a reset mid-stream discards all buffered blocks.

Configuration
REQ-029 SHALL with macro SHIFT_ROWS_PIPE_STATS_EN defined add output xfer_count (16 bits): it counts out_valid&out_ready handshakes, saturates at 0xFFFF, and resets to 0.
REQ-030 SHALL without SHIFT_ROWS_PIPE_STATS_EN omit the xfer_count port and its counter entirely.

Verification
REQ-031 SHALL cover: NB=4, inv=1, in_data=00010203_04050607_08090a0b_0c0d0e0f -> out_data=00010203_07040506_0a0b0809_0d0e0f0c one cycle later.
REQ-032 SHALL cover: the same input with inv=0 -> out_data=00010203_05060704_0a0b0809_0f0c0d0e.
REQ-033 SHALL cover: NB=8, random blocks sent forward then fed back inverse -> original data returned; row 3 rotated by 4 bytes.
REQ-034 SHALL cover: out_ready held low while 3 blocks are offered -> 2 accepted, in_ready=0; then out_ready=1 -> blocks with tags 1,2 emerge in order and stay stable while stalled.
REQ-035 SHALL cover: continuous in_valid=out_ready=1 for 100 cycles with alternating modes -> 100 outputs, one per cycle, correct mode per tag; with SHIFT_ROWS_PIPE_STATS_EN, xfer_count=100.
REQ-036 SHALL cover: rst_n pulsed low with 2 blocks buffered -> out_valid=0 at once, no stale block after release, xfer_count=0.

Source files
------------

// File: rtl/shift_rows_pipe.sv
// shift_rows_pipe: AES/Rijndael ShiftRows (forward or inverse, chosen per
// block) feeding a 2-entry output FIFO, with valid/ready on both sides.
// State is row-major: byte k sits at bits [32*NB-1-8k -: 8], row r col c = byte r*NB+c.
// Optional feature: define SHIFT_ROWS_PIPE_STATS_EN to add a 16-bit saturating
// xfer_count output that counts output handshakes.

// One state row rotated by a fixed byte offset; inv selects the direction.
module shift_rows_row #(
  parameter int NB  = 4,
  parameter int OFF = 0
) (
  input  logic            inv,
  input  logic [8*NB-1:0] row_in,
  output logic [8*NB-1:0] row_out
);
  for (genvar c = 0; c < NB; c++) begin : g_col
    localparam int FS = (c + OFF) % NB;       // forward source column
    localparam int IS = (c + NB - OFF) % NB;  // inverse source column
    assign row_out[8*NB-1-8*c -: 8] = inv ? row_in[8*NB-1-8*IS -: 8]
                                          : row_in[8*NB-1-8*FS -: 8];
  end
endmodule

module shift_rows_pipe #(
  parameter int NB    = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_inv,
  input  logic [32*NB-1:0] in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [32*NB-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
`ifdef SHIFT_ROWS_PIPE_STATS_EN
  ,
  output logic [15:0]      xfer_count
`endif
);
  localparam int W = 32 * NB;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [W-1:0]     data;
  } ent_t;

  // rows[3] holds the most significant row, i.e. row 0
  logic [3:0][8*NB-1:0] rows_in, rows_out;
  assign rows_in = in_data;

  // Row 3 gets offset 4 instead of 3 (and row 2 offset 3) for 256-bit blocks
  for (genvar r = 0; r < 4; r++) begin : g_row
    localparam int OFF = (NB == 8 && r >= 2) ? r + 1 : r;
    shift_rows_row #(.NB(NB), .OFF(OFF)) u_row (
      .inv     (in_inv),
      .row_in  (rows_in[3-r]),
      .row_out (rows_out[3-r])
    );
  end

  ent_t       mem [2];
  logic       wr_ptr, rd_ptr;
  logic [1:0] cnt, cnt_nxt;
  logic       rdy_q;
  logic       acc, ret;

  // in_ready is a flop, so out_ready never reaches it combinationally
  assign in_ready  = rdy_q;
  assign out_valid = (cnt != 2'd0);
  assign out_data  = mem[rd_ptr].data;
  assign out_tag   = mem[rd_ptr].tag;
  assign acc       = in_valid & rdy_q;
  assign ret       = out_valid & out_ready;

  // Occupancy after this edge's accept/retire
  always_comb begin
    cnt_nxt = cnt + {1'b0, acc} - {1'b0, ret};
  end

  // FIFO storage, pointers and registered ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
      rdy_q  <= 1'b0;
    end else begin
      if (acc) begin
        mem[wr_ptr] <= '{tag: in_tag, data: rows_out};
        wr_ptr      <= ~wr_ptr;
      end
      if (ret) rd_ptr <= ~rd_ptr;
      cnt   <= cnt_nxt;
      rdy_q <= (cnt_nxt < 2'd2);
    end
  end

`ifdef SHIFT_ROWS_PIPE_STATS_EN
  // Saturating count of output handshakes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          xfer_count <= 16'd0;
    else if (ret && xfer_count != 16'hFFFF) xfer_count <= xfer_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Bench for shift_rows_pipe: an NB=4 and an NB=8 instance, each with an
// expected-response queue filled at acceptance and drained by an output monitor.
module tb_shift_rows_pipe;
  bit clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         iv4, ir4, inv4, ov4, or4;
  logic [127:0] d4, od4;
  logic [3:0]   tg4, ot4;
  logic         iv8, ir8, inv8, ov8, or8;
  logic [255:0] d8, od8;
  logic [3:0]   tg8, ot8;
`ifdef SHIFT_ROWS_PIPE_STATS_EN
  logic [15:0]  xc4, xc8;
`endif

  shift_rows_pipe #(.NB(4), .TAG_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .in_inv(inv4),
    .in_data(d4), .in_tag(tg4), .out_valid(ov4), .out_ready(or4),
    .out_data(od4), .out_tag(ot4)
`ifdef SHIFT_ROWS_PIPE_STATS_EN
    , .xfer_count(xc4)
`endif
  );

  shift_rows_pipe #(.NB(8), .TAG_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .in_inv(inv8),
    .in_data(d8), .in_tag(tg8), .out_valid(ov8), .out_ready(or8),
    .out_data(od8), .out_tag(ot8)
`ifdef SHIFT_ROWS_PIPE_STATS_EN
    , .xfer_count(xc8)
`endif
  );

  typedef struct { logic [255:0] d; logic [3:0] t; } exp_t;
  exp_t q4[$], q8[$];
  exp_t cur4, cur8;
  logic [255:0] cap8[$];
  int errors = 0, checks = 0, pops4 = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference ShiftRows straight from the row/offset definition
  function automatic logic [255:0] mdl(input logic [255:0] d, input logic inv, input int nb);
    logic [255:0] o = '0;
    for (int r = 0; r < 4; r++) begin
      int off = (nb == 8 && r >= 2) ? r + 1 : r;
      for (int c = 0; c < nb; c++) begin
        int s = inv ? (c - off + nb) % nb : (c + off) % nb;
        o[32*nb-1-8*(r*nb+c) -: 8] = d[32*nb-1-8*(r*nb+s) -: 8];
      end
    end
    return o;
  endfunction

  // Acceptance monitor: a block offered while ready is taken on the next edge
  always @(negedge clk) if (rst_n) begin
    if (iv4 && ir4) q4.push_back(cur4);
    if (iv8 && ir8) q8.push_back(cur8);
  end

  // Output monitors: every presented cycle must match the queue head; pop on handshake
  always @(negedge clk) if (rst_n && ov4) begin
    if (q4.size() == 0) chk("unexpected_out4", ov4, 0);
    else begin
      chk("data4", od4, q4[0].d);
      chk("tag4", ot4, q4[0].t);
      if (or4) begin void'(q4.pop_front()); pops4++; end
    end
  end

  always @(negedge clk) if (rst_n && ov8) begin
    if (q8.size() == 0) chk("unexpected_out8", ov8, 0);
    else begin
      chk("data8", od8, q8[0].d);
      chk("tag8", ot8, q8[0].t);
      if (or8) begin cap8.push_back(od8); void'(q8.pop_front()); end
    end
  end

  // Offer one block (called just after a rising edge); hold until accepted
  task automatic send(input bit big, input logic [255:0] d, input logic inv,
                      input logic [3:0] tag, input logic [255:0] exp);
    bit done = 0;
    bit rdy;
    if (big) begin iv8 = 1; d8 = d;        inv8 = inv; tg8 = tag; cur8 = '{exp, tag}; end
    else     begin iv4 = 1; d4 = d[127:0]; inv4 = inv; tg4 = tag; cur4 = '{exp, tag}; end
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      rdy = big ? ir8 : ir4;
      @(posedge clk); #1;
      if (rdy) begin done = 1; break; end
    end
    if (big) iv8 = 0; else iv4 = 0;
    chk("send_accepted", done, 1);
  endtask

  task automatic drain(input bit big);
    for (int k = 0; k < 30; k++) begin
      if ((big ? q8.size() : q4.size()) == 0) break;
      @(posedge clk); #1;
    end
    chk(big ? "drain8" : "drain4", big ? q8.size() : q4.size(), 0);
  endtask

  localparam logic [127:0] A4 = 128'h00010203_04050607_08090a0b_0c0d0e0f;
  localparam logic [127:0] F4 = 128'h00010203_05060704_0a0b0809_0f0c0d0e;
  localparam logic [127:0] I4 = 128'h00010203_07040506_0a0b0809_0d0e0f0c;
  localparam logic [255:0] V8 =
    256'h0001020304050607_08090a0b0c0d0e0f_1011121314151617_18191a1b1c1d1e1f;
  localparam logic [255:0] F8 =
    256'h0001020304050607_090a0b0c0d0e0f08_1314151617101112_1c1d1e1f18191a1b;

  logic [255:0] orig [4];
  logic [255:0] rnd;
  int p0;

  initial begin
    rst_n = 0;
    iv4 = 0; inv4 = 0; d4 = '0; tg4 = '0; or4 = 1;
    iv8 = 0; inv8 = 0; d8 = '0; tg8 = '0; or8 = 1;
    #2;
    chk("rst_out_valid", ov4, 0);
    chk("rst_in_ready", ir4, 0);
    chk("rst_out_data", od4, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;
    chk("ready_after_rst4", ir4, 1);
    chk("ready_after_rst8", ir8, 1);

    // Directed NB=4 vectors, inverse then forward
    send(0, A4, 1, 4'd1, I4);
    chk("latency_1cyc", ov4, 1);
    send(0, A4, 0, 4'd2, F4);
    drain(0);

    // NB=8 directed: row 3 rotates by 4 bytes; then inverse restores it
    send(1, V8, 0, 4'd3, F8);
    send(1, F8, 1, 4'd4, V8);
    drain(1);

    // NB=8 round trip with random blocks
    cap8.delete();
    for (int i = 0; i < 4; i++) begin
      orig[i] = {$urandom(), $urandom(), $urandom(), $urandom(),
                 $urandom(), $urandom(), $urandom(), $urandom()};
      send(1, orig[i], 0, 4'(i), mdl(orig[i], 0, 8));
    end
    drain(1);
    chk("cap8_count", cap8.size(), 4);
    for (int i = 0; i < 4; i++) send(1, cap8[i], 1, 4'(i + 8), orig[i]);
    drain(1);

    // Backpressure: two blocks fill the FIFO, the third waits
    or4 = 0;
    send(0, A4, 0, 4'd1, F4);
    send(0, A4, 1, 4'd2, I4);
    iv4 = 1; d4 = A4; inv4 = 0; tg4 = 4'd3; cur4 = '{F4, 4'd3};
    repeat (3) begin
      @(negedge clk);
      chk("full_in_ready", ir4, 0);
      chk("full_out_valid", ov4, 1);
    end
    @(posedge clk); #1;
    or4 = 1;
    send(0, A4, 0, 4'd3, F4);
    drain(0);

    // Reset with two blocks buffered
    or4 = 0;
    send(0, A4, 1, 4'd5, I4);
    send(0, A4, 0, 4'd6, F4);
    rst_n = 0;
    #1;
    chk("midrst_out_valid", ov4, 0);
    chk("midrst_in_ready", ir4, 0);
    chk("midrst_out_data", od4, 0);
    chk("midrst_out_tag", ot4, 0);
`ifdef SHIFT_ROWS_PIPE_STATS_EN
    chk("midrst_xfer_count", xc4, 0);
`endif
    q4.delete();
    @(posedge clk); #1;
    rst_n = 1; or4 = 1;
    @(posedge clk); #1;
    chk("ready_after_midrst", ir4, 1);
    repeat (4) @(posedge clk);
    #1 chk("no_stale_block", ov4, 0);

    // 100 back-to-back blocks, alternating mode
    p0 = pops4;
    for (int i = 0; i < 100; i++) begin
      rnd = {128'b0, $urandom(), $urandom(), $urandom(), $urandom()};
      iv4 = 1; d4 = rnd[127:0]; inv4 = i[0]; tg4 = i[3:0];
      cur4 = '{mdl(rnd, i[0], 4), i[3:0]};
      @(negedge clk);
      chk("burst_in_ready", ir4, 1);
      @(posedge clk); #1;
    end
    iv4 = 0;
    @(negedge clk); #1;
    chk("burst_outputs", pops4 - p0, 100);
`ifdef SHIFT_ROWS_PIPE_STATS_EN
    @(posedge clk); #1;
    chk("xfer_count_100", xc4, 100);
`endif
    drain(0);

    chk("final_q4_empty", q4.size(), 0);
    chk("final_q8_empty", q8.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
